multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control state machine for the multi-cycle build of the RV32I core. It sequences one shared ALU, one shared instruction/data memory port and the register file over several cycles per instruction. It drives the 2-bit `alu_op` consumed by the existing ALU control decoder (00 add, 01 subtract, 10 funct-decoded). It supports lw, sw, R-type, beq and an illegal-opcode trap, and keeps cycle and retired-instruction counters.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `opcode` in 7: IR[6:0]; IR is stable from DECODE until the next FETCH completes.
- `zero` in 1: ALU zero flag, same cycle.
- `mem_ready` in 1: memory completes the current request at this rising edge.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = write, valid with `mem_req`.
- `i_or_d` out 1: address mux select. 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load IR.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load when `zero` is high (datapath ANDs).
- `pc_source` out 1: PC mux select. 0 = ALU result, 1 = ALUOut.
- `alu_src_a` out 2: A mux select. 00 = PC, 01 = rs1, 10 = oldPC.
- `alu_src_b` out 2: B mux select. 00 = rs2, 01 = constant 4, 10 = immediate.
- `alu_op` out 2: to the ALU control decoder.
- `reg_write` out 1: register file write enable.
- `mem_to_reg` out 1: write-back mux select. 0 = ALUOut, 1 = MDR.
- `illegal` out 1: sticky trap flag.
- `state` out 4: current state, for debug.
- `cycle_cnt` out 32: cycles since reset.
- `instret_cnt` out 32: instructions retired.

## Operation
- States and encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, TRAP=9. Codes 10–15 return to FETCH on the next edge.
- Outputs are decoded from state. `ir_write` and `pc_write` in FETCH are additionally gated by `mem_ready`. Any output not listed for a state is 0.
- **FETCH:** `mem_req`=1, `i_or_d`=0, `alu_src_a`=00, `alu_src_b`=01, `alu_op`=00, `pc_source`=0.
  - Stay while `mem_ready`=0.
  - When `mem_ready`=1: `ir_write`=1 and `pc_write`=1, then go to DECODE.
- **DECODE:** `alu_src_a`=10, `alu_src_b`=10, `alu_op`=00 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 → MEM_ADDR.
  - 0110011 → EXECUTE.
  - 1100011 → BRANCH.
  - anything else → TRAP.
- **MEM_ADDR:** `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00. Go to MEM_READ if `opcode`=0000011, else MEM_WRITE.
- **MEM_READ:** `mem_req`=1, `i_or_d`=1, `mem_we`=0. Hold until `mem_ready`, then go to MEM_WB.
- **MEM_WB:** `reg_write`=1, `mem_to_reg`=1. Go to FETCH.
- **MEM_WRITE:** `mem_req`=1, `i_or_d`=1, `mem_we`=1. Hold until `mem_ready`, then go to FETCH.
- **EXECUTE:** `alu_src_a`=01, `alu_src_b`=00, `alu_op`=10. Go to ALU_WB.
- **ALU_WB:** `reg_write`=1, `mem_to_reg`=0. Go to FETCH.
- **BRANCH:** `alu_src_a`=01, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=1. Go to FETCH.
- **TRAP:** `illegal`=1 and all enables 0. The FSM stays in TRAP until reset.
- Handshake rules:
  - `mem_req`, `mem_we` and `i_or_d` stay constant from assertion until the edge where `mem_ready`=1.
  - `mem_ready` is ignored in states without `mem_req`.
- Counters:
  - `cycle_cnt` increments every edge while not in TRAP.
  - `instret_cnt` increments on the edge leaving MEM_WB, MEM_WRITE (with `mem_ready`), ALU_WB or BRANCH.
  - Both wrap modulo 2^32.

## Timing
- Reset (`rst_n` low, asynchronous):
  - state=FETCH, `illegal`=0, both counters 0.
  - All enable outputs (`mem_req`, `ir_write`, `pc_write`, `pc_write_cond`, `reg_write`, `mem_we`) are forced to 0 combinationally while `rst_n` is low.
- Reset mid-operation aborts any outstanding memory request without completing it. The first `mem_req` appears in the first cycle after `rst_n` rises.
- Cycle counts with zero-wait memory (`mem_ready` tied high):
  - lw: 5 cycles.
  - sw: 4 cycles.
  - R-type: 4 cycles.
  - beq: 3 cycles.
- Each wait cycle on a memory state adds exactly one cycle.
- TRAP is entered on the edge after DECODE. `illegal` rises in that cycle. `cycle_cnt` freezes at its value on entering TRAP.
- When leaving MEM_WRITE, `instret_cnt` increments on the same edge that returns the FSM to FETCH.

## Test plan
- Reset, `mem_ready`=1, opcode=0110011 held → state sequence 0,1,6,7,0. `reg_write`=1 only in state 7. `instret_cnt`=1 after 4 edges.
- lw with `mem_ready` low for 2 cycles in both FETCH and MEM_READ → states 0,0,0,1,2,3,3,3,4,0. `mem_req`, `i_or_d` and `mem_we` stay stable throughout. `cycle_cnt`=9 on the edge that returns to FETCH.
- sw with zero wait → `mem_we`=1 only in state 5. `reg_write` never asserts. 4 cycles; `instret_cnt` increments once.
- beq with `zero`=1, then with `zero`=0 → in state 8: `alu_op`=01, `pc_write_cond`=1, `pc_source`=1. Sequence 0,1,8,0 in both cases.
- opcode=1111111 → TRAP after DECODE. `illegal`=1 and `cycle_cnt` freezes. Pulsing `rst_n` low recovers to FETCH with counters 0.
- Assert `rst_n` low while in MEM_READ waiting → `mem_req`=0 immediately (asynchronous). After release the FSM restarts in FETCH.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle RV32I controller and its datapath.
// The master side is the controller; the slave side is the datapath and memory.
interface multicycle_ctrl_if;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        i_or_d;
  logic        ir_write;
  logic        pc_write;
  logic        pc_write_cond;
  logic        pc_source;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        reg_write;
  logic        mem_to_reg;
  logic        illegal;
  logic [3:0]  state;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
           alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, illegal, state,
           cycle_cnt, instret_cnt
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
           alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, illegal, state,
           cycle_cnt, instret_cnt
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences the shared ALU, the
// shared memory port and the register file, and keeps cycle/instret counters.
module multicycle_ctrl (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_TRAP      = 4'd9
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t      state_r;
  logic        illegal_r;
  logic [31:0] cycle_cnt_r;
  logic [31:0] instret_cnt_r;

  logic        mem_req_s;
  logic        mem_we_s;
  logic        i_or_d_s;
  logic        ir_write_s;
  logic        pc_write_s;
  logic        pc_write_cond_s;
  logic        pc_source_s;
  logic [1:0]  alu_src_a_s;
  logic [1:0]  alu_src_b_s;
  logic [1:0]  alu_op_s;
  logic        reg_write_s;
  logic        mem_to_reg_s;

  // State sequencing, sticky trap flag and the two free-running counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_FETCH;
      illegal_r     <= 1'b0;
      cycle_cnt_r   <= 32'd0;
      instret_cnt_r <= 32'd0;
    end else begin
      if (state_r != S_TRAP) begin
        cycle_cnt_r <= cycle_cnt_r + 32'd1;
      end else begin
        cycle_cnt_r <= cycle_cnt_r;
      end
      case (state_r)
        S_FETCH: begin
          if (bus.mem_ready) state_r <= S_DECODE;
          else               state_r <= S_FETCH;
        end
        S_DECODE: begin
          case (bus.opcode)
            OP_LOAD, OP_STORE: state_r <= S_MEM_ADDR;
            OP_RTYPE:          state_r <= S_EXECUTE;
            OP_BRANCH:         state_r <= S_BRANCH;
            default: begin
              state_r   <= S_TRAP;
              illegal_r <= 1'b1;
            end
          endcase
        end
        S_MEM_ADDR: begin
          if (bus.opcode == OP_LOAD) state_r <= S_MEM_READ;
          else                       state_r <= S_MEM_WRITE;
        end
        S_MEM_READ: begin
          if (bus.mem_ready) state_r <= S_MEM_WB;
          else               state_r <= S_MEM_READ;
        end
        S_MEM_WRITE: begin
          if (bus.mem_ready) begin
            state_r       <= S_FETCH;
            instret_cnt_r <= instret_cnt_r + 32'd1;
          end else begin
            state_r <= S_MEM_WRITE;
          end
        end
        S_EXECUTE: state_r <= S_ALU_WB;
        S_MEM_WB, S_ALU_WB, S_BRANCH: begin
          state_r       <= S_FETCH;
          instret_cnt_r <= instret_cnt_r + 32'd1;
        end
        S_TRAP:  state_r <= S_TRAP;
        default: state_r <= S_FETCH;
      endcase
    end
  end

  // Per-state control decode; only the FETCH loads depend on mem_ready.
  always_comb begin
    mem_req_s       = 1'b0;
    mem_we_s        = 1'b0;
    i_or_d_s        = 1'b0;
    ir_write_s      = 1'b0;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    pc_source_s     = 1'b0;
    alu_src_a_s     = 2'b00;
    alu_src_b_s     = 2'b00;
    alu_op_s        = 2'b00;
    reg_write_s     = 1'b0;
    mem_to_reg_s    = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_req_s   = 1'b1;
        alu_src_b_s = 2'b01;
        ir_write_s  = bus.mem_ready;
        pc_write_s  = bus.mem_ready;
      end
      S_DECODE: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b10;
      end
      S_MEM_ADDR: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
      end
      S_MEM_READ: begin
        mem_req_s = 1'b1;
        i_or_d_s  = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_req_s = 1'b1;
        i_or_d_s  = 1'b1;
        mem_we_s  = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a_s = 2'b01;
        alu_op_s    = 2'b10;
      end
      S_ALU_WB: reg_write_s = 1'b1;
      S_BRANCH: begin
        alu_src_a_s     = 2'b01;
        alu_op_s        = 2'b01;
        pc_write_cond_s = 1'b1;
        pc_source_s     = 1'b1;
      end
      S_TRAP:  mem_req_s = 1'b0;
      default: mem_req_s = 1'b0;
    endcase
  end

  // Enables are killed combinationally during reset so an aborted request drops at once.
  assign bus.mem_req       = mem_req_s       & rst_n;
  assign bus.mem_we        = mem_we_s        & rst_n;
  assign bus.ir_write      = ir_write_s      & rst_n;
  assign bus.pc_write      = pc_write_s      & rst_n;
  assign bus.pc_write_cond = pc_write_cond_s & rst_n;
  assign bus.reg_write     = reg_write_s     & rst_n;
  assign bus.i_or_d        = i_or_d_s;
  assign bus.pc_source     = pc_source_s;
  assign bus.alu_src_a     = alu_src_a_s;
  assign bus.alu_src_b     = alu_src_b_s;
  assign bus.alu_op        = alu_op_s;
  assign bus.mem_to_reg    = mem_to_reg_s;
  assign bus.illegal       = illegal_r;
  assign bus.state         = state_r;
  assign bus.cycle_cnt     = cycle_cnt_r;
  assign bus.instret_cnt   = instret_cnt_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: instruction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic clk;
  logic rst_n;
  multicycle_ctrl_if bus_if ();

  multicycle_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus_if.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // Model: an instruction is a list of states; kind 0 lw,1 sw,2 R,3 beq,4 illegal.
  int          m_kind;
  int          m_step;
  int unsigned m_cyc;
  int unsigned m_ret;
  int          trace[$];

  function automatic int kind_of(input logic [6:0] op);
    if (op == OP_LW)  return 0;
    if (op == OP_SW)  return 1;
    if (op == OP_R)   return 2;
    if (op == OP_BEQ) return 3;
    return 4;
  endfunction

  function automatic int seq_state(input int kind, input int step);
    int lw_s[5]  = '{0, 1, 2, 3, 4};
    int sw_s[4]  = '{0, 1, 2, 5};
    int r_s[4]   = '{0, 1, 6, 7};
    int beq_s[3] = '{0, 1, 8};
    int bad_s[3] = '{0, 1, 9};
    case (kind)
      0:       return lw_s[step];
      1:       return sw_s[step];
      2:       return r_s[step];
      3:       return beq_s[step];
      default: return bad_s[step];
    endcase
  endfunction

  function automatic int seq_len(input int kind);
    case (kind)
      0:       return 5;
      1, 2:    return 4;
      default: return 3;
    endcase
  endfunction

  function automatic int cur_state();
    return seq_state(m_kind, m_step);
  endfunction

  // {mem_req,mem_we,i_or_d,ir_write,pc_write,pc_write_cond,pc_source,a,b,op,reg_write,mem_to_reg}
  function automatic logic [14:0] exp_ctrl(input int st, input logic mr, input logic rn);
    logic [14:0] v;
    case (st)
      0:       v = {1'b1, 1'b0, 1'b0, mr, mr, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0};
      1:       v = {7'b0, 2'b10, 2'b10, 2'b00, 2'b00};
      2:       v = {7'b0, 2'b01, 2'b10, 2'b00, 2'b00};
      3:       v = {7'b1010000, 6'b0, 2'b00};
      4:       v = {7'b0, 6'b0, 2'b11};
      5:       v = {7'b1110000, 6'b0, 2'b00};
      6:       v = {7'b0, 2'b01, 2'b00, 2'b10, 2'b00};
      7:       v = {7'b0, 6'b0, 2'b10};
      8:       v = {7'b0000011, 2'b01, 2'b00, 2'b01, 2'b00};
      default: v = 15'd0;
    endcase
    if (!rn) v = v & 15'b010_0100_0000_0001 & ~15'b010_0000_0000_0000 | (v & 15'b001_0011_1111_1101);
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_kind = 0;
    m_step = 0;
    m_cyc  = 0;
    m_ret  = 0;
  endtask

  task automatic model_step(input logic mr, input logic [6:0] op);
    int st;
    st = cur_state();
    if (st == 9) return;
    m_cyc++;
    if ((st == 0 || st == 3 || st == 5) && !mr) return;
    if (m_step == 1) m_kind = kind_of(op);
    if (m_kind == 4 && m_step == 2) return;
    m_step++;
    if (m_step == seq_len(m_kind)) begin
      m_step = 0;
      m_ret++;
    end
  endtask

  // Every cycle, away from the edge: all outputs against the model.
  always @(negedge clk) begin
    #2;
    if (chk_on) begin
      check("state", {28'd0, bus_if.state}, cur_state());
      check("ctrl", {17'd0, bus_if.mem_req, bus_if.mem_we, bus_if.i_or_d, bus_if.ir_write,
                     bus_if.pc_write, bus_if.pc_write_cond, bus_if.pc_source, bus_if.alu_src_a,
                     bus_if.alu_src_b, bus_if.alu_op, bus_if.reg_write, bus_if.mem_to_reg},
            {17'd0, exp_ctrl(cur_state(), bus_if.mem_ready, rst_n)});
      check("illegal", {31'd0, bus_if.illegal}, (cur_state() == 9) ? 32'd1 : 32'd0);
      check("cycle_cnt", bus_if.cycle_cnt, m_cyc);
      check("instret_cnt", bus_if.instret_cnt, m_ret);
    end
  end

  task automatic cycle(input logic mr, input logic z, input logic [6:0] op);
    @(negedge clk);
    bus_if.mem_ready = mr;
    bus_if.zero      = z;
    if (m_step == 0) bus_if.opcode = op;
    #3;
    trace.push_back(int'(bus_if.state));
    @(posedge clk);
    if (rst_n) model_step(mr, bus_if.opcode);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mem_req", {31'd0, bus_if.mem_req}, 32'd0);
    check("rst_state", {28'd0, bus_if.state}, 32'd0);
    check("rst_cycle", bus_if.cycle_cnt, 32'd0);
    check("rst_instret", bus_if.instret_cnt, 32'd0);
    check("rst_illegal", {31'd0, bus_if.illegal}, 32'd0);
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    trace.delete();
  endtask

  task automatic check_trace(input string nm, input int exp_q[$]);
    check({nm, "_len"}, trace.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < trace.size(); i++)
      check(nm, trace[i], exp_q[i]);
  endtask

  initial begin
    int trap_cycles;
    logic [6:0] rop;
    rst_n            = 1'b0;
    bus_if.opcode    = OP_R;
    bus_if.zero      = 1'b0;
    bus_if.mem_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // R-type, zero wait: 0,1,6,7 then back in FETCH with one retired.
    do_reset();
    repeat (4) cycle(1'b1, 1'b0, OP_R);
    #1;
    check_trace("r_seq", '{0, 1, 6, 7});
    check("r_state_end", {28'd0, bus_if.state}, 32'd0);
    check("r_instret", bus_if.instret_cnt, 32'd1);
    check("r_cycle", bus_if.cycle_cnt, 32'd4);

    // lw with two wait cycles in FETCH and in MEM_READ.
    do_reset();
    begin
      logic mr_pat[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 9; i++) cycle(mr_pat[i], 1'b0, OP_LW);
    end
    #1;
    check_trace("lw_seq", '{0, 0, 0, 1, 2, 3, 3, 3, 4});
    check("lw_state_end", {28'd0, bus_if.state}, 32'd0);
    check("lw_cycle", bus_if.cycle_cnt, 32'd9);
    check("lw_instret", bus_if.instret_cnt, 32'd1);

    // sw zero wait, then beq taken and not taken.
    do_reset();
    repeat (4) cycle(1'b1, 1'b0, OP_SW);
    repeat (3) cycle(1'b1, 1'b1, OP_BEQ);
    repeat (3) cycle(1'b1, 1'b0, OP_BEQ);
    #1;
    check_trace("sw_beq_seq", '{0, 1, 2, 5, 0, 1, 8, 0, 1, 8});
    check("sw_beq_instret", bus_if.instret_cnt, 32'd3);
    check("sw_beq_cycle", bus_if.cycle_cnt, 32'd10);

    // Illegal opcode: trap after DECODE, counter frozen, reset recovers.
    do_reset();
    repeat (2) cycle(1'b1, 1'b0, OP_BAD);
    #1;
    check("trap_state", {28'd0, bus_if.state}, 32'd9);
    check("trap_illegal", {31'd0, bus_if.illegal}, 32'd1);
    check("trap_cycle", bus_if.cycle_cnt, 32'd2);
    repeat (3) cycle(1'b1, 1'b0, OP_BAD);
    #1;
    check("trap_cycle_frozen", bus_if.cycle_cnt, 32'd2);
    check("trap_instret", bus_if.instret_cnt, 32'd0);
    do_reset();

    // Reset while MEM_READ is waiting: request drops immediately.
    repeat (3) cycle(1'b1, 1'b0, OP_LW);
    repeat (2) cycle(1'b0, 1'b0, OP_LW);
    #1;
    check("mr_wait_state", {28'd0, bus_if.state}, 32'd3);
    do_reset();

    // Randomized traffic against the model.
    trap_cycles = 0;
    for (int n = 0; n < 3000; n++) begin
      if (cur_state() == 9) trap_cycles++;
      if (trap_cycles > 3 || $urandom_range(0, 299) == 0) begin
        do_reset();
        trap_cycles = 0;
      end else begin
        case ($urandom_range(0, 40))
          0:              rop = 7'($urandom_range(0, 127));
          1, 2, 3, 4, 5:  rop = OP_BEQ;
          default: begin
            case ($urandom_range(0, 2))
              0:       rop = OP_LW;
              1:       rop = OP_SW;
              default: rop = OP_R;
            endcase
          end
        endcase
        cycle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)), rop);
      end
    end

    @(negedge clk);
    #4;
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
